// File: rtl/adder_response_checker_pkg.sv
// Shared definitions for the full-adder response checker.
// Holds the FSM state encoding, the full-coverage mask, the first_err
// bit-field layout and two small helpers that build the coverage index and
// the packed first_err capture.
package adder_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] COV_ALL = 8'hFF;

  // first_err = {a, b, ci, carry, sum}
  localparam int unsigned FE_W     = 5;
  localparam int unsigned FE_A     = 4;
  localparam int unsigned FE_B     = 3;
  localparam int unsigned FE_CI    = 2;
  localparam int unsigned FE_CARRY = 1;
  localparam int unsigned FE_SUM   = 0;

  // Coverage bit index: ci is the most significant bit, b the least.
  function automatic logic [2:0] cov_idx(input logic ci, input logic a, input logic b);
    return {ci, a, b};
  endfunction

  function automatic logic [FE_W-1:0] pack_first_err(input logic a, input logic b,
                                                     input logic ci, input logic carry,
                                                     input logic sum);
    logic [FE_W-1:0] f;
    f           = '0;
    f[FE_A]     = a;
    f[FE_B]     = b;
    f[FE_CI]    = ci;
    f[FE_CARRY] = carry;
    f[FE_SUM]   = sum;
    return f;
  endfunction

endpackage

// File: rtl/adder_response_checker_full_adder_ref.sv
// Golden 1-bit full-adder model (purely combinational).
// Ports: a, b, ci -> sum, carry.
module full_adder_ref (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ ci;
  assign carry = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder_response_checker.sv
// Response checker for a 1-bit full adder under exhaustive self-test.
// Accepts observed {a,b,ci,sum,carry} vectors over a valid/ready handshake,
// compares them against a golden model, counts vectors and errors
// (saturating), records which of the 8 input combinations were seen and the
// first mismatch, and reports pass/fail once coverage is complete.
// Ports:
//   clk, rst (sync, active-high), start (one-cycle arm/clear pulse)
//   in_valid / in_ready (in_ready is the only combinational output)
//   in_a, in_b, in_ci, in_sum, in_carry : observed DUT vector
//   busy, done, pass                    : status
//   vec_count, err_count                : saturating CNT_W-bit counters
//   coverage                            : bit {ci,a,b} set when seen
//   first_err, first_err_valid          : {a,b,ci,carry,sum} of first mismatch
module adder_response_checker
  import adder_response_checker_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_ci,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic [FE_W-1:0]  first_err,
  output logic             first_err_valid
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [7:0]       cov_q, cov_d;
  logic [FE_W-1:0]  fe_q, fe_d;
  logic             fev_q, fev_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             exp_sum;
  logic             exp_carry;
  logic             accept;
  logic             mismatch;
  logic [7:0]       cov_next;

  full_adder_ref u_ref (
    .a     (in_a),
    .b     (in_b),
    .ci    (in_ci),
    .sum   (exp_sum),
    .carry (exp_carry)
  );

  // start in the same cycle blocks acceptance so the clear is never mixed
  // with a vector update.
  assign in_ready = (state_q == ST_RUN) & ~start;
  assign accept   = in_ready & in_valid;
  assign mismatch = (in_sum ^ exp_sum) | (in_carry ^ exp_carry);
  assign cov_next = cov_q | (8'd1 << cov_idx(in_ci, in_a, in_b));

  // Next-state and result-register logic.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    fe_d    = fe_q;
    fev_d   = fev_q;
    pass_d  = pass_q;

    if (start) begin
      state_d = ST_RUN;
      vec_d   = '0;
      err_d   = '0;
      cov_d   = '0;
      fe_d    = '0;
      fev_d   = 1'b0;
      pass_d  = 1'b0;
    end else if (accept) begin
      if (vec_q != {CNT_W{1'b1}}) vec_d = vec_q + CNT_W'(1);
      cov_d = cov_next;
      if (mismatch) begin
        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
        if (!fev_q) begin
          fe_d  = pack_first_err(in_a, in_b, in_ci, in_carry, in_sum);
          fev_d = 1'b1;
        end
      end
      // err_q is never zero after a mismatch (no wrap), so it alone tracks
      // earlier failures; the current vector is folded in via mismatch.
      if (cov_next == COV_ALL) begin
        state_d = ST_DONE;
        pass_d  = ~mismatch & (err_q == '0);
      end else if (STOP_ON_ERR && mismatch) begin
        state_d = ST_DONE;
        pass_d  = 1'b0;
      end
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      fe_q    <= '0;
      fev_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      fe_q    <= fe_d;
      fev_q   <= fev_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_count       = vec_q;
  assign err_count       = err_q;
  assign coverage        = cov_q;
  assign first_err       = fe_q;
  assign first_err_valid = fev_q;

endmodule
